// File: rtl/sound_sequencer.sv
// Square-wave sound sequencer: prioritised one-shot sound requests, each
// played as a fixed tone for a whole number of prescaled duration ticks.
module sound_sequencer #(
  parameter int TICK_DIV  = 12500000,
  parameter int HALF_STEP = 113636,
  parameter int HALF_SHOT = 56818,
  parameter int HALF_BOOM = 227272,
  parameter int DUR_STEP  = 1,
  parameter int DUR_SHOT  = 1,
  parameter int DUR_BOOM  = 4
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       Req_step,
  input  logic       Req_shot,
  input  logic       Req_boom,
  output logic       Spk,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] Snd_id
);

  // One counter width covers both the prescaler and the longest half-period.
  localparam int MAX_HALF = (HALF_STEP > HALF_SHOT) ?
                            ((HALF_STEP > HALF_BOOM) ? HALF_STEP : HALF_BOOM) :
                            ((HALF_SHOT > HALF_BOOM) ? HALF_SHOT : HALF_BOOM);
  localparam int MAXV = (TICK_DIV > MAX_HALF) ? TICK_DIV : MAX_HALF;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state, next;
  logic [1:0]    snd, sel;
  logic [CW-1:0] pre, half, half_last;
  logic [3:0]    ticks, dur;
  logic          spk, start, tick, last_tick;

  // Request arbitration: highest-numbered sound wins.
  always_comb begin
    sel = 2'd0;
    if (Req_boom)      sel = 2'd3;
    else if (Req_shot) sel = 2'd2;
    else if (Req_step) sel = 2'd1;
  end

  // Per-sound tone half-period and duration in ticks.
  always_comb begin
    half_last = CW'(HALF_STEP - 1);
    dur       = 4'(DUR_STEP);
    case (snd)
      2'd2: begin half_last = CW'(HALF_SHOT - 1); dur = 4'(DUR_SHOT); end
      2'd3: begin half_last = CW'(HALF_BOOM - 1); dur = 4'(DUR_BOOM); end
      default: ;
    endcase
  end

  // A request starts a sound when idle/done, or preempts a lower-priority one.
  assign start     = (sel != 2'd0) && ((state != PLAY) || (sel > snd));
  assign tick      = (state == PLAY) && (pre == TICK_LAST);
  assign last_tick = tick && ((ticks + 4'd1) == dur);

  // State register.
  always_ff @(posedge CLK) begin
    if (Rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    next   = state;
    Busy   = 1'b0;
    Done   = 1'b0;
    Snd_id = 2'd0;
    Spk    = 1'b0;
    case (state)
      IDLE: if (start) next = PLAY;
      PLAY: begin
        Busy   = 1'b1;
        Snd_id = snd;
        Spk    = spk;
        if (start)          next = PLAY;
        else if (last_tick) next = DONE;
      end
      DONE: begin
        Done = 1'b1;
        next = start ? PLAY : IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Prescaler, tick counter and tone divider; all restart on (pre)emption.
  always_ff @(posedge CLK) begin
    if (Rst || (!start && state != PLAY)) begin
      snd   <= 2'd0;
      pre   <= '0;
      half  <= '0;
      ticks <= 4'd0;
      spk   <= 1'b0;
    end else if (start) begin
      snd   <= sel;
      pre   <= '0;
      half  <= '0;
      ticks <= 4'd0;
      spk   <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) ticks <= ticks + 4'd1;
      if (half == half_last) begin
        half <= '0;
        spk  <= ~spk;
      end else begin
        half <= half + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with small timing parameters.
// Cycle c is the interval after clock edge c-1; a request "at c" is sampled
// by edge c. Outputs are checked as {Spk, Busy, Done, Snd_id}.
module tb_sound_sequencer;

  logic       CLK = 1'b0;
  logic       Rst = 1'b1;
  logic       Req_step = 1'b0, Req_shot = 1'b0, Req_boom = 1'b0;
  logic       Spk, Busy, Done;
  logic [1:0] Snd_id;

  int checks = 0;
  int errors = 0;

  sound_sequencer #(
    .TICK_DIV(8), .HALF_STEP(3), .HALF_SHOT(2), .HALF_BOOM(4),
    .DUR_STEP(2), .DUR_SHOT(1), .DUR_BOOM(3)
  ) dut (
    .CLK(CLK), .Rst(Rst), .Req_step(Req_step), .Req_shot(Req_shot),
    .Req_boom(Req_boom), .Spk(Spk), .Busy(Busy), .Done(Done), .Snd_id(Snd_id)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Req_step = i[0]; Req_shot = ~i[0]; Req_boom = i[1];
      cyc();
      got = {Spk, Busy, Done, Snd_id};
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL reset cyc %0d got %b exp %b", i, got, 5'b0);
      end
    end
    Rst = 1'b0; Req_step = 1'b0; Req_shot = 1'b0; Req_boom = 1'b0;
    cyc();
    got = {Spk, Busy, Done, Snd_id};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", got, 5'b0);
    end
  endtask

  task automatic test_shot();
    logic [4:0] got, exp;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        if (c <= 8)       exp = {1'(((c - 1) / 2) % 2), 1'b1, 1'b0, 2'd2};
        else if (c == 9)  exp = 5'b0_0_1_00;
        else              exp = 5'b0;
        got = {Spk, Busy, Done, Snd_id};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL shot cyc %0d got %b exp %b", c, got, exp);
        end
      end
      Req_shot = (c == 0);
      cyc();
    end
    Req_shot = 1'b0;
  endtask

  task automatic test_preempt();
    logic [4:0] got, exp;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) begin
        if (c <= 4)       exp = {1'(((c - 1) / 2) % 2), 1'b1, 1'b0, 2'd2};
        else if (c <= 28) exp = {1'(((c - 5) / 4) % 2), 1'b1, 1'b0, 2'd3};
        else if (c == 29) exp = 5'b0_0_1_00;
        else              exp = 5'b0;
        got = {Spk, Busy, Done, Snd_id};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL preempt cyc %0d got %b exp %b", c, got, exp);
        end
      end
      Req_shot = (c == 0);
      Req_boom = (c == 4);
      cyc();
    end
    Req_shot = 1'b0; Req_boom = 1'b0;
  endtask

  // Boom with a lower-priority request mid-sound, or all three at once.
  task automatic test_boom(input bit all_three);
    logic [4:0] got, exp;
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) begin
        if (c <= 24)      exp = {1'(((c - 1) / 4) % 2), 1'b1, 1'b0, 2'd3};
        else if (c == 25) exp = 5'b0_0_1_00;
        else              exp = 5'b0;
        got = {Spk, Busy, Done, Snd_id};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL boom%s cyc %0d got %b exp %b",
                   all_three ? "_all" : "_ign", c, got, exp);
        end
      end
      Req_boom = (c == 0);
      Req_shot = all_three && (c == 0);
      Req_step = all_three ? (c == 0) : (c == 6);
      cyc();
    end
    Req_boom = 1'b0; Req_shot = 1'b0; Req_step = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [4:0] got, exp;
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) begin
        if (c <= 10)      exp = {1'(((c - 1) / 3) % 2), 1'b1, 1'b0, 2'd1};
        else if (c <= 12) exp = 5'b0;
        else if (c <= 20) exp = {1'(((c - 13) / 2) % 2), 1'b1, 1'b0, 2'd2};
        else if (c == 21) exp = 5'b0_0_1_00;
        else              exp = 5'b0;
        got = {Spk, Busy, Done, Snd_id};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rst_abort cyc %0d got %b exp %b", c, got, exp);
        end
      end
      Req_step = (c == 0);
      Rst      = (c == 10);
      Req_shot = (c == 12);
      cyc();
    end
    Req_step = 1'b0; Rst = 1'b0; Req_shot = 1'b0;
  endtask

  // Equal-priority request ignored; a request in DONE restarts immediately.
  task automatic test_back_to_back();
    logic [4:0] got, exp;
    for (int c = 0; c <= 27; c++) begin
      if (c > 0) begin
        if (c <= 8)       exp = {1'(((c - 1) / 2) % 2), 1'b1, 1'b0, 2'd2};
        else if (c == 9)  exp = 5'b0_0_1_00;
        else if (c <= 25) exp = {1'(((c - 10) / 3) % 2), 1'b1, 1'b0, 2'd1};
        else if (c == 26) exp = 5'b0_0_1_00;
        else              exp = 5'b0;
        got = {Spk, Busy, Done, Snd_id};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b cyc %0d got %b exp %b", c, got, exp);
        end
      end
      Req_shot = (c == 0) || (c == 3);
      Req_step = (c == 9);
      cyc();
    end
    Req_shot = 1'b0; Req_step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shot();
    test_preempt();
    test_boom(1'b0);
    test_boom(1'b1);
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
